// File: rtl/alu_pkg.sv
// Shared definitions for the operand-entry path of the multicycle ALU datapath:
// controller state encoding and BCD digit constants.
package alu_pkg;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic digitInvalid(input logic [DIGIT_W-1:0] digit);
    return digit > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_mac.sv
// One Horner step of BCD-to-binary conversion: acc_out = acc_in*10 + digit.
// The x10 uses shift-and-add at OUT_W+4 bits and is truncated back to OUT_W.
module bcd_digit_mac
  import alu_pkg::*;
#(
  parameter int OUT_W = 14
) (
  input  logic [OUT_W-1:0]   acc_in,
  input  logic [DIGIT_W-1:0] digit,
  output logic [OUT_W-1:0]   acc_out
);

  localparam int WIDE_W = OUT_W + DIGIT_W;

  logic [WIDE_W-1:0] w_accWide;
  logic [WIDE_W-1:0] w_digitWide;

  assign w_accWide   = WIDE_W'(acc_in);
  assign w_digitWide = WIDE_W'(digit);

  assign acc_out = OUT_W'((w_accWide << 3) + (w_accWide << 1) + w_digitWide);

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Multicycle BCD-to-binary converter, MSD first, one digit per clock.
// go is edge-detected; done/err/binary hold until the next accepted start.
module bcd_to_bin_seq
  import alu_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int OUT_W   = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       go,
  input  logic [DIGIT_W*NDIGITS-1:0] bcd_in,
  output logic [OUT_W-1:0]           binary,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int SH_W  = DIGIT_W * NDIGITS;
  localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  state_t             r_state;
  state_t             w_nextState;
  logic               r_goQ;
  logic [SH_W-1:0]    r_sh;
  logic [OUT_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_bad;
  logic [OUT_W-1:0]   r_binary;
  logic               r_err;

  logic               w_start;
  logic               w_capture;
  logic               w_lastDigit;
  logic               w_bad;
  logic [OUT_W-1:0]   w_accNext;

  assign w_start     = go & ~r_goQ;
  assign w_lastDigit = (r_cnt == CNT_W'(NDIGITS - 1));

  bcd_digit_mac #(
    .OUT_W (OUT_W)
  ) u_mac (
    .acc_in  (r_acc),
    .digit   (r_sh[SH_W-1 -: DIGIT_W]),
    .acc_out (w_accNext)
  );

  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (digitInvalid(bcd_in[i*DIGIT_W +: DIGIT_W])) begin
        w_bad = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A start is honoured from IDLE or DONE only; during ACC it is dropped.
  always_comb begin
    w_nextState = r_state;
    w_capture   = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start) begin
          w_capture   = 1'b1;
          w_nextState = ST_ACC;
        end
      end
      ST_ACC: begin
        if (w_lastDigit) begin
          w_nextState = ST_DONE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // go_q resets high so a go held through reset is not seen as a new request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_goQ    <= 1'b1;
      r_sh     <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_bad    <= 1'b0;
      r_binary <= '0;
      r_err    <= 1'b0;
    end else begin
      r_goQ <= go;
      if (w_capture) begin
        r_sh  <= bcd_in;
        r_acc <= '0;
        r_cnt <= '0;
        r_bad <= w_bad;
        r_err <= 1'b0;
      end else if (r_state == ST_ACC) begin
        r_acc <= w_accNext;
        r_sh  <= r_sh << DIGIT_W;
        r_cnt <= r_cnt + 1'b1;
        if (w_lastDigit) begin
          r_binary <= r_bad ? '0 : w_accNext;
          r_err    <= r_bad;
        end
      end
    end
  end

  assign binary = r_binary;
  assign err    = r_err;
  assign busy   = (r_state == ST_ACC);
  assign done   = (r_state == ST_DONE);

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Bench for bcd_to_bin_seq: a cycle-level behavioural model checked every cycle,
// plus directed conversions with hand-computed results.
module tb_bcd_to_bin_seq;

  localparam int NDIGITS = 4;
  localparam int OUT_W   = 14;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   go = 1'b1;
  logic [4*NDIGITS-1:0]   bcdIn = '0;
  logic [OUT_W-1:0]       binary;
  logic                   busy;
  logic                   done;
  logic                   err;

  int errorCount = 0;
  int checkCount = 0;
  bit checkEn = 1'b0;

  // Model: 0 = idle, 1 = converting, 2 = result held
  int mPhase = 0;
  int mLeft = 0;
  int mBin = 0;
  bit mErr = 1'b0;
  bit mGoPrev = 1'b1;
  int pendVal = 0;
  bit pendErr = 1'b0;

  bcd_to_bin_seq #(
    .NDIGITS (NDIGITS),
    .OUT_W   (OUT_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .go     (go),
    .bcd_in (bcdIn),
    .binary (binary),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  // Reference decimal value as a weighted sum of digits.
  function automatic void convert(input logic [4*NDIGITS-1:0] b, output int val, output bit bad);
    int weight;
    int d;
    val = 0;
    bad = 1'b0;
    weight = 1;
    for (int i = 0; i < NDIGITS; i++) begin
      d = int'(b[i*4 +: 4]);
      if (d > 9) bad = 1'b1;
      val = val + d * weight;
      weight = weight * 10;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rstVal, input logic goVal, input logic [4*NDIGITS-1:0] bcdVal);
    @(negedge clk);
    rst   = rstVal;
    go    = goVal;
    bcdIn = bcdVal;
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("doneTimeout", {31'd0, done}, 32'd1);
  endtask

  task automatic convertValue(input logic [4*NDIGITS-1:0] bcdVal, input int expBin, input bit expErr, input string name);
    applyStimulus(1'b0, 1'b0, bcdVal);
    applyStimulus(1'b0, 1'b1, bcdVal);
    waitDone();
    checkOutput({name, "_bin"}, 32'(binary), 32'(expBin));
    checkOutput({name, "_err"}, {31'd0, err}, {31'd0, expErr});
    checkOutput({name, "_done"}, {31'd0, done}, 32'd1);
    applyStimulus(1'b0, 1'b0, bcdVal);
  endtask

  always @(posedge clk) begin
    bit startEv;
    if (rst) begin
      mPhase  = 0;
      mBin    = 0;
      mErr    = 1'b0;
      mGoPrev = 1'b1;
    end else begin
      startEv = go && !mGoPrev;
      mGoPrev = go;
      case (mPhase)
        0, 2: begin
          if (startEv) begin
            convert(bcdIn, pendVal, pendErr);
            mLeft  = NDIGITS;
            mPhase = 1;
            mErr   = 1'b0;
          end
        end
        1: begin
          mLeft--;
          if (mLeft == 0) begin
            mPhase = 2;
            mBin   = pendErr ? 0 : pendVal;
            mErr   = pendErr;
          end
        end
        default: mPhase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busy", {31'd0, busy}, {31'd0, mPhase == 1});
      checkOutput("done", {31'd0, done}, {31'd0, mPhase == 2});
      checkOutput("err", {31'd0, err}, {31'd0, mErr});
      checkOutput("binary", 32'(binary), 32'(mBin));
    end
  end

  initial begin
    int v;
    bit e;

    convert(16'h0255, v, e);
    checkOutput("model0255", 32'(v), 32'd255);
    convert(16'h9999, v, e);
    checkOutput("model9999", 32'(v), 32'd9999);
    convert(16'h01A3, v, e);
    checkOutput("model01A3err", {31'd0, e}, 32'd1);

    repeat (3) applyStimulus(1'b1, 1'b1, 16'h0000);
    checkEn = 1'b1;
    applyStimulus(1'b0, 1'b1, 16'h0255);
    repeat (5) applyStimulus(1'b0, 1'b1, 16'h0255);
    checkOutput("heldGoBusy", {31'd0, busy}, 32'd0);
    checkOutput("heldGoDone", {31'd0, done}, 32'd0);

    convertValue(16'h0255, 255, 1'b0, "c0255");
    convertValue(16'h9999, 14'h270F, 1'b0, "c9999");
    convertValue(16'h0000, 0, 1'b0, "c0000");
    convertValue(16'h01A3, 0, 1'b1, "c01A3");

    applyStimulus(1'b0, 1'b0, 16'h0123);
    applyStimulus(1'b0, 1'b1, 16'h0123);
    applyStimulus(1'b0, 1'b0, 16'h0123);
    applyStimulus(1'b0, 1'b1, 16'h0999);
    waitDone();
    checkOutput("ignoredGo_bin", 32'(binary), 32'd123);
    repeat (3) applyStimulus(1'b0, 1'b1, 16'h0999);
    checkOutput("heldDone_bin", 32'(binary), 32'd123);
    applyStimulus(1'b0, 1'b0, 16'h0999);

    applyStimulus(1'b0, 1'b1, 16'h1234);
    applyStimulus(1'b0, 1'b1, 16'h1234);
    applyStimulus(1'b1, 1'b0, 16'h1234);
    applyStimulus(1'b0, 1'b0, 16'h1234);
    checkOutput("abort_bin", 32'(binary), 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_err", {31'd0, err}, 32'd0);
    convertValue(16'h0042, 42, 1'b0, "c0042");

    repeat (2) applyStimulus(1'b0, 1'b0, 16'h0000);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
